booth_mult_arbiter: RTL
=======================

# booth_mult_arbiter

Two-port arbiter and sequencer for a shared radix-2 Booth multiply engine. It accepts signed multiply requests from two requesters, grants one at a time by round-robin, and runs the Booth add/subtract/arithmetic-shift iterations internally, one bit per clock. It returns the signed 2·WIDTH product with a one-cycle `done` strobe tagged with the served requester. It sits between the lab's requester blocks and the multiplier datapath, so the multiplier is instantiated once and shared.

## Interface
- `WIDTH`, default 8: operand width in bits; two's complement; WIDTH ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req0`, `req1` input 1 each: request; held high with operands stable until own `done`.
- `mcand0`, `mplier0` input WIDTH each: requester 0 operands; signed.
- `mcand1`, `mplier1` input WIDTH each: requester 1 operands; signed.
- `gnt0`, `gnt1` output 1 each: one-hot grant; high from grant edge through DONE cycle.
- `busy` output 1: high in any state other than IDLE.
- `product` output 2·WIDTH: signed result; holds until next `done`.
- `done` output 1: one-cycle completion strobe.
- `done_id` output 1: requester served by the current `done` (0 or 1); holds until next `done`.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; `gnt0`, `gnt1`, `busy`, `done`, `done_id` = 0; `product` = 0; priority pointer = 0 (req0 favoured).
- IDLE → RUN when any req is sampled high:
  - Only one req high: that requester wins.
  - Both high: the requester selected by the pointer wins.
  - On the grant edge: set the winner's `gnt`; latch M = mcand, Q = mplier, Q₋₁ = 0, A = 0, count = WIDTH.
- RUN, each edge:
  - {Q0, Q₋₁} = 01: A += M; 10: A −= M; 00 or 11: no add.
  - Then arithmetic right shift of {A, Q, Q₋₁} by 1; count −= 1.
  - A is held WIDTH+1 bits wide, with M sign-extended, so −2^(WIDTH−1) × −2^(WIDTH−1) is exact.
- RUN → DONE on the edge that performs the final iteration (count 1 → 0):
  - `product` ← low 2·WIDTH bits of {A, Q}.
  - `done` ← 1; `done_id` ← winner.
  - Pointer ← the non-served requester.
- DONE → IDLE unconditionally:
  - `done`, `gnt`, and `busy` clear on this edge.
  - The requester must drop `req` by this edge, or it is re-granted.
- Req asserted while busy: held pending and considered at the next IDLE sample.
- Req dropped during RUN: the operation completes and `done` still pulses. Operands are latched, so input changes after the grant are ignored.
- Reset asserted in any state:
  - Operation abandoned; no `done` pulse.
  - All outputs and the pointer return to their reset values on that edge.

## Timing
- Grant: `gnt` and `busy` high one edge after `req` is sampled in IDLE.
- Latency: `done` high WIDTH edges after the grant edge (8 for the default).
- Throughput: one multiply per WIDTH+2 cycles per port when requests are back-to-back.
- `product` and `done_id` are registered; `done` is exactly one cycle wide.

## Configuration
- `BOOTH_ZERO_SKIP_EN` defined:
  - If the latched mcand or mplier is 0 at the grant edge, RUN is skipped.
  - The next edge enters DONE with `product` = 0, so `done` comes 1 edge after grant.
  - Pointer and handshake rules are unchanged.
- `BOOTH_ZERO_SKIP_EN` undefined: every operation takes the full WIDTH iterations.

## Test plan
- WIDTH=8, reset, then req0 with 13 × 11 → `gnt0` next cycle; `done` 8 edges after grant; `product`=143, `done_id`=0; `busy` low the cycle after `done`.
- Corner operands on port 0:
  - −128 × −128 → `product` = 16384 (0x4000).
  - 127 × −128 → −16256 (0xC080).
  - −1 × −1 → 1.
- req0 and req1 both held high from reset, each with distinct operands and each dropping req on its own `done`, for 4 operations → `done_id` sequence 0, 1, 0, 1; `gnt` always one-hot; each product correct.
- Mid-operation and late-arrival behaviour:
  - req1 raised during port-0 RUN → port 0 completes, then port 1 is granted at the first IDLE sample.
  - req0 dropped mid-RUN → its `done` still pulses with the correct product.
- `reset` pulsed on the 4th RUN cycle → no `done`; `gnt0`, `busy`, `product` = 0 on the next cycle; a fresh req1 with 5 × −3 → product −15, `done_id`=1.
- Zero operands, 0 × −5 → `product`=0:
  - With `BOOTH_ZERO_SKIP_EN`: `done` 1 edge after grant.
  - Without: `done` 8 edges after grant.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin two-port front end for one shared radix-2 Booth multiplier, one bit per clock.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand finishes one edge after grant with product 0.
module booth_mult_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     mcand0,
    input  logic [WIDTH-1:0]     mplier0,
    input  logic [WIDTH-1:0]     mcand1,
    input  logic [WIDTH-1:0]     mplier1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 done_id
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic                    ptr, win, sel;
    logic [WIDTH-1:0]        op_a, op_b;
    logic signed [WIDTH:0]   acc, m_ext, sum;
    logic [WIDTH:0]          acc_sh;
    logic [WIDTH-1:0]        q, q_sh;
    logic                    q_m1;
    logic [CW-1:0]           count;
    logic                    last;
    logic [2*WIDTH-1:0]      fin;
`ifdef BOOTH_ZERO_SKIP_EN
    logic                    zero;
`endif

    // A lone requester always wins; the pointer only breaks ties.
    assign sel  = (req0 && req1) ? ptr : !req0;
    assign op_a = sel ? mcand1  : mcand0;
    assign op_b = sel ? mplier1 : mplier0;

    always_comb begin
        case ({q[0], q_m1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    // Arithmetic shift of {A, Q, Q-1} after the add/subtract.
    assign acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    assign q_sh   = {sum[0], q[WIDTH-1:1]};

`ifdef BOOTH_ZERO_SKIP_EN
    assign last = (count == CW'(1)) || zero;
    assign fin  = zero ? '0 : {acc_sh[WIDTH-1:0], q_sh};
`else
    assign last = (count == CW'(1));
    assign fin  = {acc_sh[WIDTH-1:0], q_sh};
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        gnt0 = busy && !win;
        gnt1 = busy && win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= 1'b0;
            win     <= 1'b0;
            product <= '0;
            done_id <= 1'b0;
            acc     <= '0;
            m_ext   <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
            zero    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    win   <= sel;
                    m_ext <= {op_a[WIDTH-1], op_a};
                    q     <= op_b;
                    q_m1  <= 1'b0;
                    acc   <= '0;
                    count <= CW'(WIDTH);
`ifdef BOOTH_ZERO_SKIP_EN
                    zero  <= (op_a == '0) || (op_b == '0);
`endif
                end
                RUN: begin
                    acc   <= acc_sh;
                    q     <= q_sh;
                    q_m1  <= q[0];
                    count <= count - 1'b1;
                    if (last) begin
                        product <= fin;
                        done_id <= win;
                        ptr     <= !win;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
